// File: rtl/cmd_fifo_pkg.sv
// rtl/cmd_fifo_pkg.sv - command word field offsets and count-width helper for cmd_fifo
package cmd_fifo_pkg;

    // Control bit positions within inst, relative to DATA_W.
    localparam int RE_OFS    = 0;
    localparam int WE_OFS    = 1;
    localparam int FLUSH_OFS = 2;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cmd_fifo_mem.sv
// rtl/cmd_fifo_mem.sv - simple dual-port RAM, one write port, one registered read port, no reset
module cmd_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read-first: a pop and push on the same slot (full FIFO) returns the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - command-decoded FIFO; sticky overflow/underflow flags under CMD_FIFO_ERR_FLAGS_EN
module cmd_fifo
    import cmd_fifo_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W+2:0]          inst,
    output logic [DATA_W-1:0]          DO,
    output logic                       read_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [DATA_W-1:0] wdata;
    logic              re, we, flush;
    logic              rd_acc, wr_acc;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          read_valid_q;
    logic          do_loaded_q;
    logic [DATA_W-1:0] mem_rdata;

    assign wdata = inst[DATA_W-1:0];
    assign re    = inst[DATA_W+RE_OFS];
    assign we    = inst[DATA_W+WE_OFS];
    assign flush = inst[DATA_W+FLUSH_OFS];

    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AF_C);

    // No fall-through: a read needs a stored word, a full write needs a concurrent pop.
    assign rd_acc = re & ~flush & ~empty;
    assign wr_acc = we & ~flush & (~full | rd_acc);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + 1'b1;
            if (rd_acc) rptr_d = rptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            read_valid_q <= 1'b0;
            do_loaded_q  <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            read_valid_q <= rd_acc;
            do_loaded_q  <= do_loaded_q | rd_acc;
        end
    end

    cmd_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (wdata),
        .re_i    (rd_acc),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata)
    );

    // RAM output is unreset and only reloads on a pop, so it already holds between reads;
    // the loaded bit masks it to zero from reset until the first pop.
    assign DO         = do_loaded_q ? mem_rdata : '0;
    assign read_valid = read_valid_q;
    assign count      = count_q;

`ifdef CMD_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (we && full && !rd_acc) overflow_q  <= 1'b1;
            if (re && empty)           underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_fifo.sv
// tb/tb_cmd_fifo.sv - scoreboard bench for cmd_fifo (DATA_W=32, DEPTH=16)
module tb_cmd_fifo;

`ifdef CMD_FIFO_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [34:0] inst;
    logic [31:0] dout;
    logic        read_valid, full, empty, almost_full, overflow, underflow;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    cmd_fifo #(.DATA_W(32), .DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst        (inst),
        .DO          (dout),
        .read_valid  (read_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [34:0] mk(logic f, logic w, logic r, logic [31:0] d);
        return {f, w, r, d};
    endfunction

    task automatic step(input logic [34:0] v);
        inst = v;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every read_valid must match the oldest expected word.
    always @(negedge clk) begin
        if (rst && read_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_read_valid", dout, 32'hFFFF_FFFF);
            end else begin
                chk("read_data", dout, sb.pop_front());
            end
        end
    end

    initial begin
        rst  = 1'b0;
        inst = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_do", dout, 0);
        chk("rst_rv", 32'(read_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);
        rst = 1'b1;

        // Basic ordering
        step(mk(0, 1, 0, 32'h11));
        step(mk(0, 1, 0, 32'h22));
        step(mk(0, 1, 0, 32'h33));
        chk("three_count", 32'(count), 3);
        sb.push_back(32'h11); step(mk(0, 0, 1, 0));
        sb.push_back(32'h22); step(mk(0, 0, 1, 0));
        sb.push_back(32'h33); step(mk(0, 0, 1, 0));
        step(mk(0, 0, 0, 0));
        chk("three_empty", 32'(empty), 1);
        chk("three_count0", 32'(count), 0);
        chk("three_rv_low", 32'(read_valid), 0);

        // Fill to full, almost_full boundary at 14, overflow
        for (int k = 0; k < 16; k++) begin
            step(mk(0, 1, 0, 32'h1000 + k));
            if (k == 12) chk("af_at13", 32'(almost_full), 0);
            if (k == 13) chk("af_at14", 32'(almost_full), 1);
            if (k == 14) chk("full_at15", 32'(full), 0);
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);
        step(mk(0, 1, 0, 32'hDEAD));
        chk("ovf_count", 32'(count), 16);
        chk("ovf_flag", 32'(overflow), 32'(ERR_EN));

        // Full with RE+WE: pop oldest, push BEEF
        sb.push_back(32'h1000);
        step(mk(0, 1, 1, 32'hBEEF));
        chk("rw_full_count", 32'(count), 16);
        chk("rw_full_full", 32'(full), 1);
        for (int k = 1; k < 16; k++) begin
            sb.push_back(32'h1000 + k);
            step(mk(0, 0, 1, 0));
        end
        sb.push_back(32'hBEEF);
        step(mk(0, 0, 1, 0));
        step(mk(0, 0, 0, 0));
        chk("drain_empty", 32'(empty), 1);
        chk("ovf_sticky", 32'(overflow), 32'(ERR_EN));

        // Empty with RE+WE: write only, underflow
        step(mk(0, 1, 1, 32'h55));
        chk("rw_empty_rv", 32'(read_valid), 0);
        chk("rw_empty_unf", 32'(underflow), 32'(ERR_EN));
        chk("rw_empty_count", 32'(count), 1);
        sb.push_back(32'h55);
        step(mk(0, 0, 1, 0));
        step(mk(0, 0, 0, 0));
        chk("do_hold", dout, 32'h55);
        chk("do_hold_rv", 32'(read_valid), 0);

        // Flush with RE overrides
        for (int k = 0; k < 8; k++) step(mk(0, 1, 0, 32'h300 + k));
        chk("pre_flush_count", 32'(count), 8);
        step(mk(1, 0, 1, 0));
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_rv", 32'(read_valid), 0);
        chk("flush_ovf", 32'(overflow), 0);
        chk("flush_unf", 32'(underflow), 0);
        chk("flush_do", dout, 32'h55);
        step(mk(0, 0, 0, 0));

        // 40 pairs with pointer wrap and a mid-stream reset
        for (int k = 0; k < 4; k++) step(mk(0, 1, 0, 32'h100 + k));
        for (int i = 0; i < 20; i++) begin
            sb.push_back(i < 4 ? 32'h100 + i : 32'h200 + i - 4);
            step(mk(0, 1, 1, 32'h200 + i));
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_rv", 32'(read_valid), 0);
        chk("mid_rst_do", dout, 0);
        sb.delete();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) step(mk(0, 1, 0, 32'h400 + k));
        chk("post_rst_count", 32'(count), 3);
        for (int i = 0; i < 20; i++) begin
            sb.push_back(i < 3 ? 32'h400 + i : 32'h500 + i - 3);
            step(mk(0, 1, 1, 32'h500 + i));
        end
        chk("pairs_count", 32'(count), 3);
        step(mk(0, 0, 0, 0));
        step(mk(0, 0, 0, 0));
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_fifo.md
CMD_FIFO -- requirements
Module: cmd_fifo

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits, range 1..64.
REQ-002 Parameter DEPTH, default 16: number of entries; a power of two in the range 2..1024.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: occupancy at or above which almost_full asserts.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port inst, input, DATA_W+3 bits: command word; [DATA_W-1:0] = data, [DATA_W] = RE, [DATA_W+1] = WE, [DATA_W+2] = FLUSH.
REQ-007 Port DO, output, DATA_W bits: read data.
REQ-008 Port read_valid, output, 1 bit: DO carries a freshly popped word this cycle.
REQ-009 Port full and port empty, outputs, 1 bit each: occupancy status.
REQ-010 Port almost_full, output, 1 bit: asserted when count >= AF_LEVEL.
REQ-011 Port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-012 Ports overflow and underflow, outputs, 1 bit each: sticky error flags (see Configuration).

Function
REQ-013 The block decodes inst combinationally each cycle into data, RE, WE and FLUSH.
REQ-014 A write is accepted when WE=1 and FLUSH=0, and either not full, or full with a read accepted in the same cycle.
REQ-015 A read is accepted when RE=1, FLUSH=0 and not empty. There is no fall-through: RE+WE on an empty FIFO accepts the write only.
REQ-016 An accepted read updates DO to the oldest word and asserts read_valid for exactly one cycle, on the cycle after acceptance (latency 1).
REQ-017 DO holds its last value when no read is accepted; read_valid is otherwise 0.
REQ-018 Write and read pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-019 count increments on a write-only, decrements on a read-only, and is unchanged on a simultaneous accepted read and write.
REQ-020 full = (count == DEPTH), empty = (count == 0), almost_full = (count >= AF_LEVEL); all three are combinational from registered count.
REQ-021 FLUSH=1 overrides RE/WE: pointers and count go to 0 on the next edge, no read_valid is produced for that cycle, and DO holds.
REQ-022 A rejected write does not modify the storage array; a rejected read does not move the read pointer.

Reset
REQ-023 While rst=0: pointers=0, count=0, DO=0, read_valid=0, overflow=0, underflow=0; storage contents are don't-care.
REQ-024 Reset asserted mid-operation discards all entries immediately (asynchronously); the first accepted write after release lands in slot 0.

Configuration
REQ-025 Macro CMD_FIFO_ERR_FLAGS_EN, defined: overflow is set by WE=1 rejected because full; underflow is set by RE=1 rejected because empty.
REQ-026 With CMD_FIFO_ERR_FLAGS_EN defined, overflow and underflow stay set until FLUSH or reset.
REQ-027 Macro CMD_FIFO_ERR_FLAGS_EN undefined: overflow and underflow are tied to 0 and no flag logic is synthesised.

Structure
REQ-028 Package cmd_fifo_pkg holds the inst bit-index offsets (RE_OFS=0, WE_OFS=1, FLUSH_OFS=2, relative to DATA_W) and a count-width function.
REQ-029 Storage is a sub-module cmd_fifo_mem: simple dual-port RAM with one write port, one synchronous read port, parameterised DATA_W and DEPTH, and no reset.
REQ-030 Pointer/count control, decode and flags reside in cmd_fifo.

Verification
REQ-031 Write 0x11, 0x22, 0x33, then RE three times -> DO=0x11, 0x22, 0x33 on consecutive cycles, each with read_valid=1 one cycle after its RE; then empty=1, count=0.
REQ-032 DEPTH=16: 16 writes -> full=1, count=16; a 17th write (0xDEAD) is rejected, overflow=1 (macro defined), and subsequent reads return the original 16 in order.
REQ-033 Full FIFO with RE+WE 0xBEEF -> count stays 16, oldest word popped; after draining, 0xBEEF is the last word out.
REQ-034 Empty FIFO with RE+WE 0x55 -> read_valid=0, underflow=1, count=1; next RE -> DO=0x55.
REQ-035 8 entries then FLUSH with RE=1 -> next cycle count=0, empty=1, read_valid=0, flags cleared, DO unchanged.
REQ-036 40 write/read pairs through DEPTH=16 (pointer wrap) with rst pulsed low mid-stream -> outputs at reset values immediately; post-reset data order is correct.
